// File: rtl/intc_pkg.sv
// Shared constants, register offsets and FSM state type for the interrupt controller.
package intc_pkg;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  // Register offsets inside the 3-register window
  localparam logic [1:0] OFF_MASK = 2'd0;
  localparam logic [1:0] OFF_PEND = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RAISE,
    ACK,
    GAP
  } state_t;

  // One-hot vector selecting source `id`
  function automatic logic [NUM_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_SRC'(1) << id;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake: raise + source ID towards the CPU, ack back.
// The controller uses the master modport, the CPU the slave modport.
interface interrupt_controller_if;
  import intc_pkg::*;

  logic            CPU_INT_RAISE;
  logic [ID_W-1:0] CPU_INT_ID;
  logic            CPU_INT_ACK;

  modport master (
    output CPU_INT_RAISE,
    output CPU_INT_ID,
    input  CPU_INT_ACK
  );

  modport slave (
    input  CPU_INT_RAISE,
    input  CPU_INT_ID,
    output CPU_INT_ACK
  );

endinterface

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder (bit 0 highest priority).
module intc_prio_enc
  import intc_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one assigned
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = i[ID_W-1:0];
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-detects four peripheral raise lines,
// masks and prioritises them, presents one interrupt at a time to the CPU and
// routes the CPU acknowledge back to the originating peripheral as a 1-cycle pulse.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             BUS_ADDR,
  inout  wire  [7:0]             BUS_DATA,
  input  logic                   BUS_WE,
  input  logic [NUM_SRC-1:0]     IRQ_IN,
  output logic [NUM_SRC-1:0]     IRQ_ACK_OUT,
  interrupt_controller_if.master cpu
);

  // Architectural state
  logic [NUM_SRC-1:0] irq_q, irq_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic               rd_en_q, rd_en_d;
  logic [7:0]         rd_data_q, rd_data_d;

  // FSM state and its registered outputs
  state_t             state_q;
  logic [ID_W-1:0]    id_q;
  logic               raise_q;
  logic [NUM_SRC-1:0] ack_out_q;

  // Bus decode
  logic [7:0]         offset;
  logic               in_win;
  logic               wr_mask;
  logic               wr_pend;
  logic [NUM_SRC-1:0] wr_data;
  logic               unused_bus_bits;

  // Arbitration
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic [NUM_SRC-1:0] pend_set;
  logic [NUM_SRC-1:0] pend_clr;
  logic               busy;

  // Modulo-256 offset keeps the window test correct even near the top of the map
  assign offset  = BUS_ADDR - BASE_ADDR;
  assign in_win  = (offset < 8'd3);
  assign wr_mask = BUS_WE && in_win && (offset[1:0] == OFF_MASK);
  assign wr_pend = BUS_WE && in_win && (offset[1:0] == OFF_PEND);
  assign wr_data = BUS_DATA[NUM_SRC-1:0];
  // Upper data bits carry nothing for this block on writes
  assign unused_bus_bits = ^BUS_DATA[7:NUM_SRC];

  assign eligible = pend_q & mask_q;
  assign busy     = (state_q != IDLE);

  intc_prio_enc u_prio_enc (
    .req   (eligible),
    .id    (win_id),
    .valid (win_valid)
  );

  // Next-state for edge detect, mask, pending set/clear and the registered read path
  always_comb begin
    irq_d    = IRQ_IN;
    pend_set = IRQ_IN & ~irq_q;
    pend_clr = '0;
    if (wr_pend) begin
      pend_clr = pend_clr | wr_data;
    end
    if (state_q == ACK) begin
      pend_clr = pend_clr | id_onehot(id_q);
    end
    // A set in the same cycle as a clear wins
    pend_d = (pend_q & ~pend_clr) | pend_set;

    mask_d = wr_mask ? wr_data : mask_q;

    rd_en_d = in_win && !BUS_WE;
    case (offset[1:0])
      OFF_MASK: rd_data_d = {{(8-NUM_SRC){1'b0}}, mask_q};
      OFF_PEND: rd_data_d = {{(8-NUM_SRC){1'b0}}, pend_q};
      OFF_STAT: rd_data_d = {busy, {(7-ID_W){1'b0}}, id_q};
      default:  rd_data_d = 8'h00;
    endcase
  end

  // Register bank and read-path flops
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q     <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      irq_q     <= irq_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Present/ack FSM; outputs are registered so they change only on state transitions
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      id_q      <= '0;
      raise_q   <= 1'b0;
      ack_out_q <= '0;
    end else begin
      ack_out_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            id_q    <= win_id;
            raise_q <= 1'b1;
            state_q <= RAISE;
          end
        end
        RAISE: begin
          // Completes regardless of later MASK/PEND changes for this source
          if (cpu.CPU_INT_ACK) begin
            raise_q   <= 1'b0;
            ack_out_q <= id_onehot(id_q);
            state_q   <= ACK;
          end
        end
        ACK: begin
          state_q <= GAP;
        end
        GAP: begin
          // Dead cycle so the peripheral can drop its raise before rearbitration
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu.CPU_INT_RAISE = raise_q;
  assign cpu.CPU_INT_ID    = id_q;
  assign IRQ_ACK_OUT       = ack_out_q;

  // Drive the shared bus only while a registered read of this window is active
  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-cycle vector table for the
// single-source and priority flows, hand-written sequences for bus corner cases.
module tb_interrupt_controller;

  localparam logic [7:0] BASE      = 8'hF0;
  localparam logic [7:0] A_MASK    = BASE + 8'd0;
  localparam logic [7:0] A_PEND    = BASE + 8'd1;
  localparam logic [7:0] A_STAT    = BASE + 8'd2;
  localparam logic [7:0] A_IDLE    = 8'h00;
  localparam logic [7:0] RELEASED  = 8'hFF;  // pulled-up value of an undriven bus

  logic       clk;
  logic       reset;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] irq_in;
  logic [3:0] irq_ack_out;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  int total;
  int bad;

  interrupt_controller_if cpu_if ();

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup pu (bus_data[gi]);
  end

  interrupt_controller #(.BASE_ADDR(BASE)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .BUS_ADDR    (bus_addr),
    .BUS_DATA    (bus_data),
    .BUS_WE      (bus_we),
    .IRQ_IN      (irq_in),
    .IRQ_ACK_OUT (irq_ack_out),
    .cpu         (cpu_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       ack;
    logic       exp_raise;
    logic [1:0] exp_id;
    logic [3:0] exp_ackout;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_drv   = 1'b1;
    tb_wdata = d;
    tick();
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = A_IDLE;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b0;
    tick();
    d = bus_data;
    bus_addr = A_IDLE;
  endtask

  task automatic run_vecs(input int first, input int count, input string tag);
    for (int i = first; i < first + count; i++) begin
      irq_in = vecs[i].irq;
      cpu_if.CPU_INT_ACK = vecs[i].ack;
      tick();
      check($sformatf("%s[%0d] raise", tag, i), {7'd0, cpu_if.CPU_INT_RAISE}, {7'd0, vecs[i].exp_raise});
      check($sformatf("%s[%0d] ackout", tag, i), {4'd0, irq_ack_out}, {4'd0, vecs[i].exp_ackout});
      if (vecs[i].exp_raise) begin
        check($sformatf("%s[%0d] id", tag, i), {6'd0, cpu_if.CPU_INT_ID}, {6'd0, vecs[i].exp_id});
      end
    end
    cpu_if.CPU_INT_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       seen;
    total = 0;
    bad   = 0;

    // Single source, bit 0: pend, raise, ack, gap, idle
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000};
    vecs[2]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    // Priority: bits 3 and 1 together, ID 1 first, then ID 3 after the gap
    vecs[5]  = '{4'b1010, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[6]  = '{4'b1010, 1'b0, 1'b1, 2'd1, 4'b0000};
    vecs[7]  = '{4'b1010, 1'b1, 1'b0, 2'd1, 4'b0010};
    vecs[8]  = '{4'b1000, 1'b0, 1'b0, 2'd1, 4'b0000};
    vecs[9]  = '{4'b1000, 1'b0, 1'b0, 2'd1, 4'b0000};
    vecs[10] = '{4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000};
    vecs[11] = '{4'b1000, 1'b1, 1'b0, 2'd3, 4'b1000};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000};

    reset    = 1'b1;
    bus_addr = A_IDLE;
    bus_we   = 1'b0;
    irq_in   = 4'b0000;
    tb_drv   = 1'b0;
    tb_wdata = 8'h00;
    cpu_if.CPU_INT_ACK = 1'b0;
    tick();
    tick();

    check("reset raise", {7'd0, cpu_if.CPU_INT_RAISE}, 8'h00);
    check("reset ackout", {4'd0, irq_ack_out}, 8'h00);
    check("reset id", {6'd0, cpu_if.CPU_INT_ID}, 8'h00);
    check("reset bus released", bus_data, RELEASED);
    reset = 1'b0;
    tick();
    bus_read(A_MASK, rd);
    check("reset MASK", rd, 8'h00);
    bus_read(A_PEND, rd);
    check("reset PEND", rd, 8'h00);
    bus_read(A_STAT, rd);
    check("reset STAT", rd, 8'h00);
    tick();
    check("bus released after read", bus_data, RELEASED);

    // Single source
    bus_write(A_MASK, 8'h01);
    run_vecs(0, 5, "single");
    bus_read(A_PEND, rd);
    check("single PEND after ack", rd, 8'h00);

    // Priority
    bus_write(A_MASK, 8'h0F);
    run_vecs(5, 9, "prio");

    // Masking: pending without enable never raises, enabling raises within 2 cycles
    bus_write(A_MASK, 8'h00);
    irq_in = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | cpu_if.CPU_INT_RAISE;
    end
    check("masked no raise", {7'd0, seen}, 8'h00);
    bus_read(A_PEND, rd);
    check("masked PEND", rd, 8'h04);
    bus_write(A_MASK, 8'h04);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      seen = cpu_if.CPU_INT_RAISE;
    end
    check("unmask raise", {7'd0, seen}, 8'h01);
    check("unmask id", {6'd0, cpu_if.CPU_INT_ID}, 8'h02);
    cpu_if.CPU_INT_ACK = 1'b1;
    tick();
    check("unmask ackout", {4'd0, irq_ack_out}, 8'h04);
    cpu_if.CPU_INT_ACK = 1'b0;
    irq_in = 4'b0000;
    tick();
    check("unmask ack pulse ends", {4'd0, irq_ack_out}, 8'h00);
    tick();

    // W1C race: set wins over a same-cycle clear; a held line does not re-trigger
    bus_write(A_MASK, 8'h00);
    irq_in = 4'b0010;
    bus_write(A_PEND, 8'h02);
    bus_read(A_PEND, rd);
    check("w1c race PEND", rd, 8'h02);
    bus_write(A_PEND, 8'h02);
    bus_read(A_PEND, rd);
    check("w1c clear held line", rd, 8'h00);
    irq_in = 4'b0000;
    tick();

    // Mask cleared mid-flight: the interrupt still completes
    bus_write(A_MASK, 8'h01);
    irq_in = 4'b0001;
    tick();
    tick();
    check("midflight raise", {7'd0, cpu_if.CPU_INT_RAISE}, 8'h01);
    bus_write(A_MASK, 8'h00);
    bus_read(A_STAT, rd);
    check("midflight STAT busy", rd, 8'h80);
    check("midflight still raised", {7'd0, cpu_if.CPU_INT_RAISE}, 8'h01);
    cpu_if.CPU_INT_ACK = 1'b1;
    tick();
    check("midflight ackout", {4'd0, irq_ack_out}, 8'h01);
    cpu_if.CPU_INT_ACK = 1'b0;
    irq_in = 4'b0000;
    tick();
    tick();

    // Reset during ACK drops the pulse and clears everything
    bus_write(A_MASK, 8'h01);
    irq_in = 4'b0001;
    tick();
    tick();
    cpu_if.CPU_INT_ACK = 1'b1;
    tick();
    check("pre-reset ackout", {4'd0, irq_ack_out}, 8'h01);
    cpu_if.CPU_INT_ACK = 1'b0;
    reset  = 1'b1;
    irq_in = 4'b0000;
    tick();
    check("reset-in-ack ackout", {4'd0, irq_ack_out}, 8'h00);
    check("reset-in-ack raise", {7'd0, cpu_if.CPU_INT_RAISE}, 8'h00);
    check("reset-in-ack id", {6'd0, cpu_if.CPU_INT_ID}, 8'h00);
    reset = 1'b0;
    bus_read(A_STAT, rd);
    check("post-reset STAT", rd, 8'h00);
    bus_read(A_MASK, rd);
    check("post-reset MASK", rd, 8'h00);

    // Outside the window the bus stays released
    bus_addr = 8'h50;
    bus_we   = 1'b0;
    tick();
    check("outside window released", bus_data, RELEASED);
    bus_addr = A_IDLE;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped interrupt controller on the shared 8-bit processor bus. It collects interrupt-raise lines from up to four peripherals (mouse, timer, IR, spare) and applies a per-source enable mask. It prioritises pending sources, presents one interrupt at a time to the CPU with a source ID, and routes the CPU acknowledge back to the originating peripheral's `BUS_INTERRUPT_ACK` as a one-cycle pulse.

## Interface
Parameters:
- `BASE_ADDR`, 8'hF0: base of the 3-register window (`BASE+0..BASE+2`).
- `NUM_SRC`, 4: number of sources, fixed at 4 and not overridable; `ID` is 2 bits.

Ports:
- `CLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high reset.
- `BUS_ADDR`  in  8  processor bus address.
- `BUS_DATA`  inout  8  processor bus data; driven only during a registered read of this block, else `Z`.
- `BUS_WE`  in  1  bus write strobe, sampled on `CLK`.
- `IRQ_IN`  in  4  peripheral raise lines (level, held until acked); bit 0 is highest priority.
- `IRQ_ACK_OUT`  out  4  per-source ack pulse, one-hot, 1 cycle.
- `CPU_INT_RAISE`  out  1  interrupt request to CPU.
- `CPU_INT_ID`  out  2  ID of the source being presented; valid while `CPU_INT_RAISE` is high.
- `CPU_INT_ACK`  in  1  CPU acknowledge.

## Operation
- Edge detect: register `irq_q <= IRQ_IN`.
  - On `IRQ_IN[i] & ~irq_q[i]`, set `PEND[i]`.
  - A line held high never re-triggers.
- `PEND[i]` clears on:
  - the internal ack of source `i`, or
  - a bus write of 1 to bit `i` of `BASE+1` (write-1-to-clear).
  - A set event in the same cycle as a clear wins (bit stays 1).
- Register map:
  - `BASE+0` MASK: R/W, bits 3:0 are enables; reset 0x00. Bits 7:4 read 0, writes ignored.
  - `BASE+1` PEND: R / W1C, bits 3:0.
  - `BASE+2` STAT: R only. Bit 7 = `busy` (FSM not IDLE), bits 1:0 = current `ID`, others 0. Writes ignored.
- Eligible set is `E = PEND & MASK`. Winner is the lowest set index of `E`.
- FSM states:
  - IDLE: if `E != 0`, latch winner into `ID` and go to RAISE.
  - RAISE: `CPU_INT_RAISE = 1`. When `CPU_INT_ACK` is sampled high, go to ACK.
  - ACK: `IRQ_ACK_OUT[ID] = 1` for exactly this cycle; clear `PEND[ID]`; go to GAP.
  - GAP: one dead cycle, then IDLE. This lets the peripheral drop its raise before rearbitration.
- Once in RAISE, the interrupt completes even if `MASK[ID]` or `PEND[ID]` is cleared meanwhile.
- Sources that become pending during RAISE, ACK or GAP wait; no preemption.
- `CPU_INT_ACK` in IDLE, ACK or GAP is ignored.
- Bus reads:
  - Address decode is registered.
  - If `BUS_ADDR` is in the window and `BUS_WE` = 0 at edge `k`, `BUS_DATA` is driven with that register's value from edge `k` until the edge where the condition is false.
  - Addresses outside the window never drive.

## Timing
- Reset values:
  - all outputs 0, FSM in IDLE, `ID` = 0;
  - `MASK`, `PEND`, `irq_q` all 0;
  - `BUS_DATA` released (`Z`).
- `RESET` asserted in any state returns everything to reset values on the next edge; an in-flight ack pulse is dropped.
- Latency:
  - `IRQ_IN` rise sampled at edge `k` → `PEND` set after `k`.
  - `CPU_INT_RAISE` high after `k+1` (2 cycles) when enabled and the FSM is IDLE.
- Ack path:
  - `CPU_INT_ACK` sampled at edge `m` → `CPU_INT_RAISE` low and `IRQ_ACK_OUT` pulse high after `m`.
  - `PEND` bit cleared after `m+1`.
  - Next raise possible after `m+3`.
- A MASK write at edge `k` takes effect for arbitration at edge `k+1`.

## Structure
- Package `intc_pkg`:
  - register offsets `OFF_MASK`=0, `OFF_PEND`=1, `OFF_STAT`=2;
  - state enum {IDLE, RAISE, ACK, GAP};
  - `NUM_SRC`, ID width.
- Sub-module `intc_prio_enc`: combinational 4→2 lowest-index priority encoder with a `valid` output. Everything else lives in the top.

## Test plan
- Single source: `MASK`=0x01, pulse `IRQ_IN[0]` high → `CPU_INT_RAISE`=1 two cycles later with `ID`=0; assert `CPU_INT_ACK` → `IRQ_ACK_OUT`=0001 for one cycle, `PEND`=0x00.
- Priority: `MASK`=0x0F, `IRQ_IN` bits 3 and 1 rise together → `ID`=1 served first, then `ID`=3 after the GAP; two ack pulses, 0010 then 1000.
- Masking: `MASK`=0x00, raise `IRQ_IN[2]` → no `CPU_INT_RAISE`, `PEND` reads 0x04; write `MASK`=0x04 → raise with `ID`=2 within 2 cycles.
- W1C race: write 0x02 to `PEND` in the same cycle `IRQ_IN[1]` rises → `PEND[1]` stays 1.
- Mask change mid-flight: in RAISE with `ID`=0, write `MASK`=0x00 → interrupt still completes, `IRQ_ACK_OUT`=0001.
- Reset mid-ACK plus bus reads:
  - `RESET` during ACK → all outputs 0 next cycle; reading `BASE+2` afterwards returns 0x00.
  - Reading 0x50 (outside the window) leaves `BUS_DATA`=Z.
